// File: rtl/priority_classifier_if.sv
// Bundle for priority_classifier: one AXI-Stream ingress, N_QUEUES flattened egress lanes
// and the per-lane statistics outputs. 'slave' is the classifier's view, 'master' the surroundings.
interface priority_classifier_if #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_USER_WIDTH = 8,
  parameter int N_QUEUES        = 3,
  parameter int CNT_WIDTH       = 32
);
  logic [AXIS_DATA_WIDTH-1:0]          s_axis_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]          s_axis_tkeep;
  logic                                s_axis_tvalid;
  logic                                s_axis_tready;
  logic                                s_axis_tlast;
  logic [AXIS_USER_WIDTH-1:0]          s_axis_tuser;
  logic [N_QUEUES*AXIS_DATA_WIDTH-1:0] m_axis_tdata;
  logic [N_QUEUES*AXIS_KEEP_WIDTH-1:0] m_axis_tkeep;
  logic [N_QUEUES-1:0]                 m_axis_tvalid;
  logic [N_QUEUES-1:0]                 m_axis_tready;
  logic [N_QUEUES-1:0]                 m_axis_tlast;
  logic [N_QUEUES*AXIS_USER_WIDTH-1:0] m_axis_tuser;
  logic [N_QUEUES*CNT_WIDTH-1:0]       stat_pkt_count;
  logic [CNT_WIDTH-1:0]                stat_drop_count;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           stat_pkt_count, stat_drop_count
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           stat_pkt_count, stat_drop_count
  );
endinterface

// File: rtl/priority_classifier.sv
// Packet classifier: steers each AXI-Stream packet to one of N_QUEUES lanes by the tuser priority
// of its head beat. Define PRIO_CLASS_STATS_EN to build the per-lane / drop packet counters.
module priority_classifier_lane #(
  parameter int W     = 64,
  parameter int K     = 8,
  parameter int U     = 8,
  parameter int SEL_W = 2,
  parameter int LANE  = 0
) (
  input  logic             valid_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic [W-1:0]     data_i,
  input  logic [K-1:0]     keep_i,
  input  logic             last_i,
  input  logic [U-1:0]     user_i,
  output logic             tvalid_o,
  output logic [W-1:0]     tdata_o,
  output logic [K-1:0]     tkeep_o,
  output logic             tlast_o,
  output logic [U-1:0]     tuser_o
);
  assign tvalid_o = valid_i && (sel_i == SEL_W'(LANE));
  assign tdata_o  = data_i;
  assign tkeep_o  = keep_i;
  assign tlast_o  = last_i;
  assign tuser_o  = user_i;
endmodule

module priority_classifier #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_USER_WIDTH = 8,
  parameter int N_QUEUES        = 3,
  parameter int PRIO_LSB        = 0,
  parameter int DROP_INVALID    = 1,
  parameter int CNT_WIDTH       = 32
) (
  input logic                 clk,
  input logic                 rst,
  priority_classifier_if.slave axis
);
  localparam int SEL_W = $clog2(N_QUEUES);
  localparam logic [2:0] NQ = 3'(N_QUEUES);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  state_e                     state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic [SEL_W-1:0]           out_sel_q, out_sel_d;
  logic [AXIS_DATA_WIDTH-1:0] data_q, data_d;
  logic [AXIS_KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                       last_q, last_d;
  logic [AXIS_USER_WIDTH-1:0] user_q, user_d;

  logic [1:0]       prio;
  logic             prio_ok, head_drop;
  logic [SEL_W-1:0] head_sel;
  logic             lane_rdy, s_ready, accept, load, cnt_pkt, cnt_drop;

  assign prio      = axis.s_axis_tuser[PRIO_LSB +: 2];
  assign prio_ok   = {1'b0, prio} < NQ;
  assign head_drop = !prio_ok && (DROP_INVALID != 0);
  assign head_sel  = prio_ok ? SEL_W'(prio) : SEL_W'(N_QUEUES-1);
  assign lane_rdy  = axis.m_axis_tready[out_sel_q];

  always_comb begin
    s_ready     = (state_q == DROP) || !out_valid_q || lane_rdy;
    accept      = axis.s_axis_tvalid && s_ready;
    state_d     = state_q;
    out_valid_d = out_valid_q && !lane_rdy;
    out_sel_d   = out_sel_q;
    load        = 1'b0;
    cnt_drop    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (head_drop) begin
          state_d  = axis.s_axis_tlast ? IDLE : DROP;
          cnt_drop = axis.s_axis_tlast;
        end else begin
          load      = 1'b1;
          out_sel_d = head_sel;
          state_d   = axis.s_axis_tlast ? IDLE : FWD;
        end
      end
      // body beats follow the lane latched at the head; their tuser priority is ignored
      FWD: if (accept) begin
        load = 1'b1;
        if (axis.s_axis_tlast) state_d = IDLE;
      end
      DROP: if (accept && axis.s_axis_tlast) begin
        state_d  = IDLE;
        cnt_drop = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    user_d = user_q;
    if (load) begin
      out_valid_d = 1'b1;
      data_d      = axis.s_axis_tdata;
      keep_d      = axis.s_axis_tkeep;
      last_d      = axis.s_axis_tlast;
      user_d      = axis.s_axis_tuser;
    end
    cnt_pkt = load && axis.s_axis_tlast;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      user_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      user_q      <= user_d;
    end
  end

  assign axis.s_axis_tready = s_ready;

  logic [N_QUEUES-1:0]                      lane_vld, lane_last;
  logic [N_QUEUES-1:0][AXIS_DATA_WIDTH-1:0] lane_data;
  logic [N_QUEUES-1:0][AXIS_KEEP_WIDTH-1:0] lane_keep;
  logic [N_QUEUES-1:0][AXIS_USER_WIDTH-1:0] lane_user;

  for (genvar i = 0; i < N_QUEUES; i++) begin : g_lane
    priority_classifier_lane #(
      .W(AXIS_DATA_WIDTH), .K(AXIS_KEEP_WIDTH), .U(AXIS_USER_WIDTH), .SEL_W(SEL_W), .LANE(i)
    ) u_lane (
      .valid_i (out_valid_q),
      .sel_i   (out_sel_q),
      .data_i  (data_q),
      .keep_i  (keep_q),
      .last_i  (last_q),
      .user_i  (user_q),
      .tvalid_o(lane_vld[i]),
      .tdata_o (lane_data[i]),
      .tkeep_o (lane_keep[i]),
      .tlast_o (lane_last[i]),
      .tuser_o (lane_user[i])
    );
  end

  assign axis.m_axis_tvalid = lane_vld;
  assign axis.m_axis_tdata  = lane_data;
  assign axis.m_axis_tkeep  = lane_keep;
  assign axis.m_axis_tlast  = lane_last;
  assign axis.m_axis_tuser  = lane_user;

`ifdef PRIO_CLASS_STATS_EN
  logic [N_QUEUES-1:0][CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]               drop_cnt_q, drop_cnt_d;

  // out_sel_d is the lane being loaded whenever cnt_pkt is set
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (cnt_pkt)  pkt_cnt_d[out_sel_d] = pkt_cnt_q[out_sel_d] + CNT_WIDTH'(1);
    if (cnt_drop) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign axis.stat_pkt_count  = pkt_cnt_q;
  assign axis.stat_drop_count = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats         = cnt_pkt ^ cnt_drop;
  assign axis.stat_pkt_count  = '0;
  assign axis.stat_drop_count = '0;
`endif
endmodule
